// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller and its slave-side peers:
// state encoding, opcode constants and word widths.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEAD      = 3'd1,
        ST_SHIFT_OUT = 3'd2,
        ST_WAIT_RD   = 3'd3,
        ST_SHIFT_IN  = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response bundle of the SPI master controller.
interface spi_master_ctrl_if
    import spi_pkg::*;
();
    logic              cmd_valid;
    logic [CMD_W-1:0]  cmd_data;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_master_shreg.sv
// Parallel-load MSB-first transmit shifter and serial-in receive assembler.
module spi_master_shreg
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CMD_W-1:0]  load_data,
    input  logic              tx_en,
    output logic              tx_msb,
    input  logic              rx_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_next
);
    logic [CMD_W-1:0]  tx_r;
    logic [DATA_W-1:0] rx_r;

    // The serial input is masked outside the receive window so an undriven line never enters the byte.
    assign rx_next = {rx_r[DATA_W-2:0], (rx_en ? rx_in : 1'b0)};
    assign tx_msb  = tx_r[CMD_W-1];

    // Shift registers: load/shift for TX, clear-on-load and shift-in for RX.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r <= {CMD_W{1'b0}};
            rx_r <= {DATA_W{1'b0}};
        end else begin
            if (load) begin
                tx_r <= load_data;
            end else if (tx_en) begin
                tx_r <= {tx_r[CMD_W-2:0], 1'b0};
            end
            if (load) begin
                rx_r <= {DATA_W{1'b0}};
            end else if (rx_en) begin
                rx_r <= rx_next;
            end
        end
    end
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: turns one 10-bit host command into one SPI frame and, for
// read-data frames, returns the 8-bit reply captured from MISO.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int LEAD    = 1,
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_ctrl_if.slave    bus,
    output logic                SS_n,
    output logic                MOSI,
    input  logic                MISO
);
    localparam int CNT_W = $clog2(max_int(max_int(LEAD, RD_WAIT), max_int(GAP, CMD_W)) + 1);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(DATA_W - 1);
    // Zero-length phases are skipped rather than entered for a cycle.
    localparam state_t POST_FRAME = (GAP == 0) ? ST_IDLE : ST_GAP;
    localparam state_t RD_ENTRY   = (RD_WAIT == 0) ? ST_SHIFT_IN : ST_WAIT_RD;

    state_t            state_r, next_state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [1:0]        op_r;
    logic              ss_n_r, mosi_r, rsp_valid_r, busy_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              load_s, tx_en_s, rx_en_s, rsp_fire_s;
    logic              ss_n_next_s, mosi_next_s, tx_msb_s;
    logic [DATA_W-1:0] rx_next_s;

    spi_master_shreg u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (bus.cmd_data),
        .tx_en     (tx_en_s),
        .tx_msb    (tx_msb_s),
        .rx_en     (rx_en_s),
        .rx_in     (MISO),
        .rx_next   (rx_next_s)
    );

    // Next-state, counter and datapath-control decode.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        load_s       = 1'b0;
        rsp_fire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = {CNT_W{1'b0}};
                if (bus.cmd_valid) begin
                    next_state_s = ST_LEAD;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (cnt_r == LEAD_LAST) begin
                    next_state_s = ST_SHIFT_OUT;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    next_state_s = ST_LEAD;
                end
            end
            ST_SHIFT_OUT: begin
                if (cnt_r == TX_LAST) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    next_state_s = (op_r == OP_RD_DATA) ? RD_ENTRY : POST_FRAME;
                end else begin
                    next_state_s = ST_SHIFT_OUT;
                end
            end
            ST_WAIT_RD: begin
                if (cnt_r == WAIT_LAST) begin
                    next_state_s = ST_SHIFT_IN;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    next_state_s = ST_WAIT_RD;
                end
            end
            ST_SHIFT_IN: begin
                if (cnt_r == RX_LAST) begin
                    next_state_s = POST_FRAME;
                    cnt_next_s   = {CNT_W{1'b0}};
                    rsp_fire_s   = 1'b1;
                end else begin
                    next_state_s = ST_SHIFT_IN;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase

        // Pins are registered from the next state so they line up with the state they belong to.
        tx_en_s     = (next_state_s == ST_SHIFT_OUT);
        rx_en_s     = (state_r == ST_SHIFT_IN);
        mosi_next_s = tx_en_s ? tx_msb_s : 1'b0;
        case (next_state_s)
            ST_LEAD, ST_SHIFT_OUT, ST_WAIT_RD, ST_SHIFT_IN: ss_n_next_s = 1'b0;
            default:                                        ss_n_next_s = 1'b1;
        endcase
    end

    // State, counter and registered outputs; reset takes priority over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_r        <= OP_WR_ADDR;
            ss_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= cnt_next_s;
            if (load_s) begin
                op_r <= bus.cmd_data[CMD_W-1 -: 2];
            end
            ss_n_r      <= ss_n_next_s;
            mosi_r      <= mosi_next_s;
            rsp_valid_r <= rsp_fire_s;
            if (rsp_fire_s) begin
                rsp_data_r <= rx_next_s;
            end
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    assign bus.cmd_ready = (state_r == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.busy      = busy_r;
    assign SS_n          = ss_n_r;
    assign MOSI          = mosi_r;
endmodule
